// File: rtl/ast_packet_upsizer.sv
`default_nettype none
// ============================================================================
//  Module   : ast_packet_upsizer
//  Purpose  : Avalon-ST packet width upsizer. Packs DATA_OUT_W/DATA_IN_W
//             narrow beats into one wide beat (first beat in the MS slot),
//             carrying sop/eop/channel/empty, with a one-word skid register
//             so the input side runs stall-free while the output drains.
//  Revision : 1.0 - initial release
// ============================================================================
module ast_packet_upsizer #(
    parameter int DATA_IN_W   = 64,
    parameter int DATA_OUT_W  = 256,
    parameter int CHANNEL_W   = 10,
    parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1)  ? $clog2(DATA_IN_W / 8)  : 1,
    parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i,
    output logic                   err_o
);

    localparam int c_ratio    = DATA_OUT_W / DATA_IN_W;
    localparam int c_cnt_w    = (c_ratio > 1) ? $clog2(c_ratio) : 1;
    localparam int c_bytes_in = DATA_IN_W / 8;
    localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(c_ratio - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    // One complete wide word with its sideband, as held in output/hold registers
    typedef struct packed {
        logic [DATA_OUT_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_OUT_W-1:0] empty;
        logic [CHANNEL_W-1:0]   chan;
    } word_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DATA_OUT_W-1:0] r_acc;
    logic                 r_first;
    logic [CHANNEL_W-1:0] r_chan;
    logic                 r_err;

    word_t                r_out;
    logic                 r_out_valid;
    word_t                r_hold;
    logic                 r_hold_full;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_beat;
    logic                 w_err;
    logic                 w_close;
    logic                 w_out_free;
    int                   w_free_slots;
    word_t                w_word;

    // Classify the accepted beat and assemble the word it would close
    always_comb begin
        w_accept     = ast_valid_i & ~r_hold_full;
        w_start      = w_accept & (r_state == ST_IDLE) & ast_startofpacket_i;
        w_beat       = w_accept & ((r_state == ST_IN_PKT) | ast_startofpacket_i);
        w_err        = w_accept & (((r_state == ST_IDLE) & ~ast_startofpacket_i) |
                                   ((r_state == ST_IN_PKT) & ast_startofpacket_i));
        w_close      = w_beat & (ast_endofpacket_i | (r_cnt == c_last_slot));
        w_out_free   = ~r_out_valid | ast_ready_i;
        // Slots left after this beat: beat k lands with RATIO-1-k slots below it
        w_free_slots = c_ratio - 1 - int'(r_cnt);

        w_word.data  = r_acc | (DATA_OUT_W'(ast_data_i) << (w_free_slots * DATA_IN_W));
        w_word.sop   = w_start | r_first;
        w_word.eop   = ast_endofpacket_i;
        w_word.empty = ast_endofpacket_i
                     ? EMPTY_OUT_W'(w_free_slots * c_bytes_in + int'(ast_empty_i))
                     : '0;
        w_word.chan  = w_start ? ast_channel_i : r_chan;
    end

    // Packet-level FSM and registered protocol-error pulse
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_beat) begin
                if (ast_endofpacket_i) begin
                    r_state <= ST_IDLE;
                end else if (w_start) begin
                    r_state <= ST_IN_PKT;
                end
            end
        end
    end

    // Beat accumulator: collects slots until the word closes, latches channel on sop
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_first <= 1'b0;
            r_chan  <= '0;
        end else begin
            if (w_start) begin
                r_chan <= ast_channel_i;
            end
            if (w_beat) begin
                if (w_close) begin
                    r_cnt   <= '0;
                    r_acc   <= '0;
                    r_first <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_acc   <= w_word.data;
                    r_first <= w_word.sop;
                end
            end
        end
    end

    // Output register plus skid register; hold always drains ahead of a new word
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_out_free) begin
                if (r_hold_full) begin
                    r_out       <= r_hold;
                    r_out_valid <= 1'b1;
                    if (w_close) begin
                        r_hold <= w_word;
                    end else begin
                        r_hold_full <= 1'b0;
                    end
                end else if (w_close) begin
                    r_out       <= w_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_close) begin
                r_hold      <= w_word;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign ast_ready_o         = ~r_hold_full;
    assign ast_data_o          = r_out.data;
    assign ast_startofpacket_o = r_out.sop;
    assign ast_endofpacket_o   = r_out.eop;
    assign ast_empty_o         = r_out.empty;
    assign ast_channel_o       = r_out.chan;
    assign ast_valid_o         = r_out_valid;
    assign err_o               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ast_packet_upsizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ast_packet_upsizer
//  Purpose  : Directed scoreboard bench for ast_packet_upsizer (64 -> 256).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ast_packet_upsizer;

    localparam int DIN = 64;
    localparam int DOUT = 256;
    localparam int CHW = 10;
    localparam int EIW = 3;
    localparam int EOW = 5;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic [DIN-1:0]  ast_data_i = '0;
    logic            ast_startofpacket_i = 1'b0;
    logic            ast_endofpacket_i = 1'b0;
    logic            ast_valid_i = 1'b0;
    logic [EIW-1:0]  ast_empty_i = '0;
    logic [CHW-1:0]  ast_channel_i = '0;
    logic            ast_ready_o;
    logic [DOUT-1:0] ast_data_o;
    logic            ast_startofpacket_o;
    logic            ast_endofpacket_o;
    logic            ast_valid_o;
    logic [EOW-1:0]  ast_empty_o;
    logic [CHW-1:0]  ast_channel_o;
    logic            ast_ready_i = 1'b1;
    logic            err_o;

    ast_packet_upsizer #(
        .DATA_IN_W  (DIN),
        .DATA_OUT_W (DOUT),
        .CHANNEL_W  (CHW)
    ) dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .ast_ready_i         (ast_ready_i),
        .err_o               (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DOUT-1:0] data;
        logic            sop;
        logic            eop;
        logic [EOW-1:0]  empty;
        logic [CHW-1:0]  chan;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic watch_ready = 1'b0;
    logic ready_dropped = 1'b0;

    task automatic chk(input string name, input logic [DOUT-1:0] act, input logic [DOUT-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [DOUT-1:0] d, input logic s, input logic e,
                                input logic [EOW-1:0] emp, input logic [CHW-1:0] ch);
        exp_t r;
        r.data = d; r.sop = s; r.eop = e; r.empty = emp; r.chan = ch;
        return r;
    endfunction

    // Monitor: every transferred output word is checked against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (arst_n && ast_valid_o && ast_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got data %h, expected no word", ast_data_o);
            end else begin
                e = sb.pop_front();
                chk("out_data", ast_data_o, e.data);
                chk("out_sop", DOUT'(ast_startofpacket_o), DOUT'(e.sop));
                chk("out_eop", DOUT'(ast_endofpacket_o), DOUT'(e.eop));
                chk("out_empty", DOUT'(ast_empty_o), DOUT'(e.empty));
                chk("out_chan", DOUT'(ast_channel_o), DOUT'(e.chan));
            end
        end
    end

    always @(negedge clk) begin
        if (watch_ready && !ast_ready_o) ready_dropped = 1'b1;
    end

    // Drive one beat; called #1 after a posedge, returns #1 after the accepting edge
    task automatic send(input logic [DIN-1:0] d, input logic s, input logic e,
                        input logic [EIW-1:0] emp, input logic [CHW-1:0] ch);
        int   cyc;
        logic ok;
        ast_data_i = d; ast_startofpacket_i = s; ast_endofpacket_i = e;
        ast_empty_i = emp; ast_channel_i = ch; ast_valid_i = 1'b1;
        cyc = 0;
        do begin
            ok = ast_ready_o;
            @(posedge clk); #1;
            cyc++;
        end while (!ok && cyc < 200);
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles, required 1", cyc);
        end
        ast_valid_i = 1'b0;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk(name, DOUT'(sb.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [DIN-1:0] d [0:11];
        for (int i = 0; i < 12; i++) d[i] = {32'hD0D0_0000 + 32'(i), 32'h1234_5600 + 32'(i)};

        // Reset state
        #12;
        chk("rst_valid", DOUT'(ast_valid_o), '0);
        chk("rst_ready", DOUT'(ast_ready_o), DOUT'(1));
        chk("rst_err", DOUT'(err_o), '0);
        chk("rst_data", ast_data_o, '0);
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #1;

        // 3-beat packet: A,B,C, empty 2 -> {A,B,C,0}, empty (4-3)*8+2 = 10
        sb.push_back(mk({64'hAAAA_AAAA_0000_0001, 64'hBBBB_BBBB_0000_0002,
                         64'hCCCC_CCCC_0000_0003, 64'h0}, 1'b1, 1'b1, 5'd10, 10'h011));
        send(64'hAAAA_AAAA_0000_0001, 1'b1, 1'b0, 3'd0, 10'h011);
        send(64'hBBBB_BBBB_0000_0002, 1'b0, 1'b0, 3'd0, 10'h011);
        send(64'hCCCC_CCCC_0000_0003, 1'b0, 1'b1, 3'd2, 10'h011);
        chk("t1_valid_latency", DOUT'(ast_valid_o), DOUT'(1));
        drain("t1_drain");

        // 8-beat packet -> two words, ready_o never drops
        sb.push_back(mk({d[0], d[1], d[2], d[3]}, 1'b1, 1'b0, 5'd0, 10'h022));
        sb.push_back(mk({d[4], d[5], d[6], d[7]}, 1'b0, 1'b1, 5'd0, 10'h022));
        watch_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(d[i], i == 0, i == 7, 3'd0, 10'h022);
        drain("t2_drain");
        watch_ready = 1'b0;
        chk("t2_ready_held", DOUT'(ready_dropped), '0);

        // 12-beat packet under backpressure
        sb.push_back(mk({d[0], d[1], d[2], d[3]}, 1'b1, 1'b0, 5'd0, 10'h021));
        sb.push_back(mk({d[4], d[5], d[6], d[7]}, 1'b0, 1'b0, 5'd0, 10'h021));
        sb.push_back(mk({d[8], d[9], d[10], d[11]}, 1'b0, 1'b1, 5'd0, 10'h021));
        ast_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) send(d[i], i == 0, 1'b0, 3'd0, 10'h021);
        chk("t3_ready_drop", DOUT'(ast_ready_o), '0);
        fork
            begin
                for (int i = 8; i < 12; i++) send(d[i], 1'b0, i == 11, 3'd0, 10'h021);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("t3_ready_still_low", DOUT'(ast_ready_o), '0);
                chk("t3_held_sop", DOUT'(ast_startofpacket_o), DOUT'(1));
                ast_ready_i = 1'b1;
            end
        join
        drain("t3_drain");

        // Channel latched on sop beat; later channel values ignored
        sb.push_back(mk({d[0], d[1], d[2], d[3]}, 1'b1, 1'b0, 5'd0, 10'h155));
        sb.push_back(mk({d[4], 64'h0, 64'h0, 64'h0}, 1'b0, 1'b1, 5'd29, 10'h155));
        for (int i = 0; i < 5; i++)
            send(d[i], i == 0, i == 4, (i == 4) ? 3'd5 : 3'd0, (i == 0) ? 10'h155 : 10'h003);
        drain("t4_drain");

        // Protocol errors: stray beat in IDLE, sop inside a packet
        send(64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0, 3'd0, 10'h3FF);
        chk("t5_err_idle", DOUT'(err_o), DOUT'(1));
        @(posedge clk); #1;
        chk("t5_err_one_cycle", DOUT'(err_o), '0);
        sb.push_back(mk({d[9], d[10], d[11], 64'h0}, 1'b1, 1'b1, 5'd12, 10'h007));
        send(d[9], 1'b1, 1'b0, 3'd0, 10'h007);
        chk("t5_err_clean_sop", DOUT'(err_o), '0);
        send(d[10], 1'b1, 1'b0, 3'd0, 10'h009);
        chk("t5_err_sop_in_pkt", DOUT'(err_o), DOUT'(1));
        send(d[11], 1'b0, 1'b1, 3'd4, 10'h009);
        chk("t5_err_cleared", DOUT'(err_o), '0);
        drain("t5_drain");

        // Reset mid-packet discards the partial packet
        send(d[0], 1'b1, 1'b0, 3'd0, 10'h0F0);
        send(d[1], 1'b0, 1'b0, 3'd0, 10'h0F0);
        #2 arst_n = 1'b0;
        #1;
        chk("t6_rst_valid", DOUT'(ast_valid_o), '0);
        chk("t6_rst_ready", DOUT'(ast_ready_o), DOUT'(1));
        chk("t6_rst_data", ast_data_o, '0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back(mk({d[4], d[5], d[6], d[7]}, 1'b1, 1'b1, 5'd0, 10'h0AA));
        for (int i = 4; i < 8; i++) send(d[i], i == 4, i == 7, 3'd0, 10'h0AA);
        chk("t6_no_err", DOUT'(err_o), '0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ast_packet_upsizer.md
Name: ast_packet_upsizer

Overview:
- Avalon-ST packet width upsizer: packs RATIO = DATA_OUT_W/DATA_IN_W narrow beats into one wide beat.
- Carries sop/eop, channel and empty through the conversion, with full backpressure.
- Extends the fixed 64→128 converter to any integer ratio, adds a skid stage for stall-free throughput, and flags protocol errors.
- Sits between a narrow packet source and a wide datapath.

Parameters:
- DATA_IN_W, 64, input data width in bits; multiple of 8.
- DATA_OUT_W, 256, output data width in bits; integer multiple of DATA_IN_W, RATIO ≥ 1.
- CHANNEL_W, 10, channel field width.
- EMPTY_IN_W, $clog2(DATA_IN_W/8) (min 1), input empty width.
- EMPTY_OUT_W, $clog2(DATA_OUT_W/8) (min 1), output empty width.

Ports:
- clk_i, in, 1, clock.
- arst_n_i, in, 1, asynchronous active-low reset.
- ast_data_i, in, DATA_IN_W, input data.
- ast_startofpacket_i, in, 1, input sop.
- ast_endofpacket_i, in, 1, input eop.
- ast_valid_i, in, 1, input valid.
- ast_empty_i, in, EMPTY_IN_W, empty symbols; meaningful only on eop.
- ast_channel_i, in, CHANNEL_W, input channel.
- ast_ready_o, out, 1, input ready.
- ast_data_o, out, DATA_OUT_W, output data.
- ast_startofpacket_o, out, 1, output sop.
- ast_endofpacket_o, out, 1, output eop.
- ast_valid_o, out, 1, output valid.
- ast_empty_o, out, EMPTY_OUT_W, output empty.
- ast_channel_o, out, CHANNEL_W, output channel.
- ast_ready_i, in, 1, downstream ready.
- err_o, out, 1, one-cycle protocol-error pulse.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except ast_ready_o = 1. Accumulator, hold register and in-packet flag are cleared. Reset mid-packet discards the partial packet; no eop is emitted for it.
- Handshakes:
  - Input beat accepted when ast_valid_i & ast_ready_o.
  - Output beat transferred when ast_valid_o & ast_ready_i.
  - Output held stable while ast_valid_o & !ast_ready_i.
- Packing:
  - First beat of each output word goes in the MS slot: beat k (0-based within the word) occupies bits [DATA_OUT_W-1-k*DATA_IN_W -: DATA_IN_W].
  - Unfilled slots are zero.
  - Beat counter 0..RATIO-1 wraps at RATIO or on eop.
- Word close: a word closes on the RATIO-th beat or on an eop beat.
  - Output sop = 1 on the first word of a packet.
  - Output eop = 1 on the closing-by-eop word.
  - ast_empty_o = (RATIO-k)*(DATA_IN_W/8) + ast_empty_i, where k = beats in the closing word (1..RATIO); 0 if not eop.
- Channel: latched on the sop beat; later in-packet channel values are ignored; every word of the packet carries the latched value.
- Buffering: two wide registers, the output register and one hold (skid) register.
  - A closing beat loads the output register directly if it is empty or draining this cycle; otherwise it loads the hold register.
  - The hold register moves to the output register when the output is empty or draining.
  - ast_ready_o = !hold_full; it is registered and independent of ast_ready_i.
- Latency: 1 cycle from acceptance of the closing beat to ast_valid_o.
- Throughput: 1 input beat per cycle while ast_ready_i = 1.
- States:
  - IDLE: waiting for sop. Beat with sop → IN_PKT (→ IDLE again if eop also set).
  - IN_PKT: accepted eop beat → IDLE.
- Errors (no stall, err_o high for exactly one cycle):
  - IDLE beat without sop: dropped, err_o pulses.
  - IN_PKT beat with sop: treated as a data beat, channel not relatched, err_o pulses.
- Simultaneous events:
  - Output drain and hold load in the same cycle → hold moves to output, the new word goes to hold.
  - Single-beat packet (sop & eop) → one word with sop = eop = 1.

Test Plan:
- Defaults, ast_ready_i = 1; 3-beat packet A,B,C with empty_i = 2 on eop → one word {A,B,C,0}, sop = eop = 1, ast_empty_o = 10, valid 1 cycle after C.
- 8-beat packet → two words; word 1 sop = 1, eop = 0, empty = 0; word 2 sop = 0, eop = 1, empty = 0; ast_ready_o stays 1 throughout.
- 12-beat packet with ast_ready_i = 0 → ast_ready_o drops the cycle after the second word closes. Release ast_ready_i → words 1..3 delivered in order, no loss or duplication.
- Sop beat with channel 0x155, later beats channel 0x003 → every output word has channel 0x155.
- Non-sop beat in IDLE → dropped, err_o = 1 for one cycle. Sop inside a packet → err_o pulse, beat packed as data.
- Reset asserted after 2 beats of a packet → outputs 0 and ast_ready_o = 1 immediately. A following 4-beat packet gives one clean word with sop = eop = 1, empty = 0.
